entity_slot_scheduler: RTL and testbench

- Owns the 9-entry entity table that feeds the detection-combination unit's entity_1..entity_7, entity_8_Flip and entity_9_Flip inputs.
- Game-logic requesters (player, enemies, sword, etc.) write slots through a round-robin arbitrated write port into a shadow table.
- The shadow table is copied to the active table once per frame, at the start of vertical blanking, so the DCU never sees a half-updated frame.

---
 rtl/entity_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 21 ++
 rtl/entity_slot_scheduler.sv | 108 ++++++++++
 tb/tb_entity_slot_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/entity_pkg.sv
// entity_pkg: shared entity-word layout, table geometry, commit line and scheduler state encoding
package entity_pkg;
  localparam int ENTITY_W = 14;
  localparam int NUM_SLOTS = 9;
  localparam logic [9:0] COMMIT_LINE = 10'd480;
  localparam logic [ENTITY_W-1:0] EMPTY_ENTITY = 14'h3C00;
  localparam int ID_LSB = 10;
  localparam int ID_W = 4;
  localparam int ORIENT_LSB = 8;
  localparam int ORIENT_W = 2;
  localparam int LOC_LSB = 0;
  localparam int LOC_W = 8;
  typedef enum logic {ACCEPT = 1'b0, COMMIT = 1'b1} state_t;
  function automatic logic slot_valid(input logic [3:0] s);
    return int'(s) < NUM_SLOTS;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first unmasked request at or after the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [PW-1:0]      pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);
  logic [NUM_REQ-1:0] elig;
  assign elig = req & ~mask;
  assign valid = |elig;
  // walk from farthest to nearest so the requester closest to the pointer wins
  always_comb begin
    grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig[(int'(pointer) + k) % NUM_REQ]) grant = NUM_REQ'(1) << ((int'(pointer) + k) % NUM_REQ);
  end
endmodule

// File: rtl/entity_slot_scheduler.sv
// entity_slot_scheduler: arbitrated shadow entity table copied to the DCU-facing active table once per frame; SLOT_READBACK_EN adds a shadow read port
module entity_slot_scheduler
  import entity_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    counter_V,
  input  logic [9:0]                    counter_H,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [4*NUM_REQ-1:0]          req_slot,
  input  logic [ENTITY_W*NUM_REQ-1:0]   req_data,
  input  logic                          clear_all,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_err,
  output logic                          frame_commit,
  output logic [ENTITY_W*NUM_SLOTS-1:0] slots_out
`ifdef SLOT_READBACK_EN
  ,
  input  logic [3:0]                    rd_slot,
  output logic [ENTITY_W-1:0]           rd_data
`endif
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_t state;
  logic [PW-1:0] ptr, ptr_next;
  logic prev_hit, clr_pend, hit, trig, valid;
  logic [NUM_REQ-1:0] grant;
  logic [3:0] sel_slot;
  logic [ENTITY_W-1:0] sel_data;
  logic [ENTITY_W-1:0] shadow [NUM_SLOTS];
  logic [ENTITY_W-1:0] active [NUM_SLOTS];
  assign hit = counter_V == COMMIT_LINE && counter_H == '0;
  assign trig = hit && !prev_hit;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req),
    .mask(gnt),
    .pointer(ptr),
    .grant(grant),
    .valid(valid)
  );
  // route the winning requester's slot/data and the pointer that follows it
  always_comb begin
    sel_slot = '0;
    sel_data = '0;
    ptr_next = ptr;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        sel_slot = req_slot[4*i +: 4];
        sel_data = req_data[ENTITY_W*i +: ENTITY_W];
        ptr_next = PW'((i + 1) % NUM_REQ);
      end
  end
  // ACCEPT: trigger beats clear beats writes; COMMIT: one-cycle parallel copy, clears deferred to ACCEPT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCEPT;
      ptr <= '0;
      prev_hit <= 1'b0;
      clr_pend <= 1'b0;
      gnt <= '0;
      wr_err <= 1'b0;
      frame_commit <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow[k] <= EMPTY_ENTITY;
        active[k] <= EMPTY_ENTITY;
      end
    end else begin
      prev_hit <= hit;
      gnt <= '0;
      wr_err <= 1'b0;
      frame_commit <= 1'b0;
      if (state == COMMIT) begin
        for (int k = 0; k < NUM_SLOTS; k++) active[k] <= shadow[k];
        frame_commit <= 1'b1;
        clr_pend <= clr_pend | clear_all;
        state <= ACCEPT;
      end else if (trig) begin
        state <= COMMIT;
      end else if (clear_all || clr_pend) begin
        for (int k = 0; k < NUM_SLOTS; k++) shadow[k] <= EMPTY_ENTITY;
        clr_pend <= 1'b0;
      end else if (valid) begin
        gnt <= grant;
        wr_err <= !slot_valid(sel_slot);
        ptr <= ptr_next;
        for (int k = 0; k < NUM_SLOTS; k++)
          if (sel_slot == 4'(k)) shadow[k] <= sel_data;
      end
    end
  end
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_out
    assign slots_out[ENTITY_W*k +: ENTITY_W] = active[k];
  end
`ifdef SLOT_READBACK_EN
  // registered shadow readback; out-of-range indices read as an empty entity
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= EMPTY_ENTITY;
      for (int k = 0; k < NUM_SLOTS; k++)
        if (rd_slot == 4'(k)) rd_data <= shadow[k];
    end
  end
`endif
endmodule

// File: tb/tb_entity_slot_scheduler.sv
// tb_entity_slot_scheduler: directed and randomized checks of entity_slot_scheduler against a frame-level reference model
module tb_entity_slot_scheduler;
  localparam logic [13:0] EMPTY = 14'h3C00;
  localparam logic [125:0] EMPTY_ALL = {9{14'h3C00}};
  logic clk, reset, clear_all, wr_err, frame_commit;
  logic [9:0] counter_V, counter_H;
  logic [2:0] req, gnt, keep;
  logic [11:0] req_slot;
  logic [41:0] req_data;
  logic [125:0] slots_out;
  logic [3:0] rslot [3];
  logic [13:0] rdata [3];
  int checks = 0, errors = 0;
  logic [13:0] msh [9];
  logic [13:0] mac [9];
  int mptr;
  bit mcommit, mpend, mprev, mwe, mfc;
  logic [2:0] meg;

  assign req_slot = {rslot[2], rslot[1], rslot[0]};
  assign req_data = {rdata[2], rdata[1], rdata[0]};

  entity_slot_scheduler dut (
    .clk(clk), .reset(reset), .counter_V(counter_V), .counter_H(counter_H),
    .req(req), .req_slot(req_slot), .req_data(req_data), .clear_all(clear_all),
    .gnt(gnt), .wr_err(wr_err), .frame_commit(frame_commit), .slots_out(slots_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [125:0] model_slots();
    logic [125:0] v;
    for (int k = 0; k < 9; k++) v[14*k +: 14] = mac[k];
    return v;
  endfunction

  // apply one clock of the specification's frame rules to the model, then compare the DUT
  task automatic cyc();
    logic [2:0] neg;
    bit nwe, nfc, hit, trig, found;
    neg = '0; nwe = 0; nfc = 0; found = 0;
    if (reset) begin
      for (int k = 0; k < 9; k++) begin msh[k] = EMPTY; mac[k] = EMPTY; end
      mptr = 0; mcommit = 0; mpend = 0; mprev = 0;
    end else begin
      hit = counter_V == 10'd480 && counter_H == 10'd0;
      trig = hit && !mprev;
      mprev = hit;
      if (mcommit) begin
        for (int k = 0; k < 9; k++) mac[k] = msh[k];
        nfc = 1; mcommit = 0;
        if (clear_all) mpend = 1;
      end else if (trig) begin
        mcommit = 1;
      end else if (clear_all || mpend) begin
        for (int k = 0; k < 9; k++) msh[k] = EMPTY;
        mpend = 0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (mptr + k) % 3;
          if (!found && req[i] && !meg[i]) begin
            found = 1;
            neg[i] = 1'b1;
            if (rslot[i] < 4'd9) msh[rslot[i]] = rdata[i]; else nwe = 1;
            mptr = (i + 1) % 3;
          end
        end
      end
    end
    meg = neg; mwe = nwe; mfc = nfc;
    @(posedge clk);
    #1;
    chk("gnt", 128'(gnt), 128'(meg));
    chk("wr_err", 128'(wr_err), 128'(mwe));
    chk("frame_commit", 128'(frame_commit), 128'(mfc));
    chk("slots_out", 128'(slots_out), 128'(model_slots()));
    for (int i = 0; i < 3; i++)
      if (meg[i]) begin
        if (keep[i]) begin
          rslot[i] = 4'($urandom_range(0, 10));
          rdata[i] = 14'($urandom);
        end else req[i] = 1'b0;
      end
    clear_all = 1'b0;
  endtask

  task automatic frame_edge();
    counter_V = 10'd480; counter_H = 10'd0; cyc();
    counter_H = 10'd1; cyc();
    counter_V = 10'd0; counter_H = 10'd5;
  endtask

  initial begin
    reset = 1; counter_V = 0; counter_H = 0; req = 0; keep = 0; clear_all = 0; meg = 0;
    for (int i = 0; i < 3; i++) begin rslot[i] = 0; rdata[i] = 0; end
    cyc(); cyc();
    reset = 0;
    chk("reset_slots", 128'(slots_out), 128'(EMPTY_ALL));
    chk("reset_gnt", 128'(gnt), 128'(3'b000));
    counter_H = 10'd5;
    req[0] = 1; rslot[0] = 4'd2; rdata[0] = 14'h0512;
    cyc();
    chk("first_grant", 128'(gnt), 128'(3'b001));
    chk("pre_commit_slot2", 128'(slots_out[28 +: 14]), 128'(EMPTY));
    frame_edge();
    chk("post_commit_slot2", 128'(slots_out[28 +: 14]), 128'(14'h0512));
    reset = 1; cyc(); reset = 0;
    keep = 3'b111; req = 3'b111;
    for (int i = 0; i < 3; i++) begin rslot[i] = 4'($urandom_range(0, 8)); rdata[i] = 14'($urandom); end
    cyc(); chk("rr_seq0", 128'(gnt), 128'(3'b001));
    cyc(); chk("rr_seq1", 128'(gnt), 128'(3'b010));
    cyc(); chk("rr_seq2", 128'(gnt), 128'(3'b100));
    cyc(); chk("rr_seq3", 128'(gnt), 128'(3'b001));
    keep = 0; req = 0;
    cyc();
    counter_V = 10'd480; counter_H = 10'd0;
    req[1] = 1; rslot[1] = 4'd5; rdata[1] = 14'h1234;
    cyc(); chk("trig_no_grant", 128'(gnt), 128'(3'b000));
    counter_H = 10'd1;
    cyc(); chk("commit_no_grant", 128'(gnt), 128'(3'b000));
    counter_V = 10'd0;
    cyc(); chk("grant_after_commit", 128'(gnt), 128'(3'b010));
    frame_edge();
    chk("next_frame_slot5", 128'(slots_out[70 +: 14]), 128'(14'h1234));
    req[2] = 1; rslot[2] = 4'd9; rdata[2] = 14'h3FFF;
    cyc(); chk("wr_err_with_gnt", 128'({gnt, wr_err}), 128'(4'b1001));
    cyc();
    frame_edge();
    req[0] = 1; rslot[0] = 4'd1; rdata[0] = 14'h0AB1;
    cyc();
    counter_V = 10'd480; counter_H = 10'd0; cyc();
    counter_H = 10'd1; clear_all = 1; cyc();
    chk("commit_before_clear", 128'(slots_out[14 +: 14]), 128'(14'h0AB1));
    counter_V = 10'd0; cyc();
    frame_edge();
    chk("clear_committed", 128'(slots_out), 128'(EMPTY_ALL));
    counter_V = 10'd480; counter_H = 10'd0;
    repeat (4) cyc();
    counter_V = 10'd0;
    for (int n = 0; n < 600; n++) begin
      reset = n == 300;
      keep = 3'($urandom);
      for (int i = 0; i < 3; i++)
        if (!req[i] && !meg[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1;
          rslot[i] = 4'($urandom_range(0, 10));
          rdata[i] = 14'($urandom);
        end
      if ($urandom_range(0, 9) == 0) begin
        counter_V = 10'd480; counter_H = 10'd0;
      end else if ($urandom_range(0, 2) == 0) begin
        counter_V = 10'($urandom_range(0, 524)); counter_H = 10'($urandom_range(0, 799));
      end
      clear_all = $urandom_range(0, 24) == 0;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
